// File: rtl/recv_protocal_stm_pkg.sv
// recv_protocal_stm_pkg: UART protocol-layer state encoding and framing defaults
package recv_protocal_stm_pkg;
   typedef enum logic [1:0] {
      NO_PROT   = 2'd0,
      WAIT_ADDR = 2'd1,
      RECV      = 2'd2,
      DROP      = 2'd3
   } prot_state_e;

   localparam logic [7:0] DEF_ADDRESS  = 8'h5A;
   localparam logic [7:0] DEF_ENDFRAME = 8'h7E;

   // A mode change takes effect at the edge, so the byte sampled there sees the new mode
   function automatic prot_state_e eff_state(prot_state_e s, logic prot_en);
      return !prot_en ? NO_PROT : (s == NO_PROT ? WAIT_ADDR : s);
   endfunction
endpackage

// File: rtl/recv_frame_timer.sv
// recv_frame_timer: inter-byte idle counter with registered expire flag
module recv_frame_timer #(
   parameter int TIMEOUT_CYC = 4096,
   parameter int TO_W = 12
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);
   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         expire <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         expire <= 1'b0;
      end else if (en) begin
         cnt <= cnt + TO_W'(1);
         expire <= (cnt + TO_W'(1)) == TO_W'(TIMEOUT_CYC - 1);
      end
   end
endmodule

// File: rtl/recv_protocal_stm.sv
// recv_protocal_stm: RX framing FSM stripping address/end-frame bytes between UART RX core and RX FIFO
module recv_protocal_stm
   import recv_protocal_stm_pkg::*;
#(
   parameter int MAX_LEN = 64,
   parameter int CNT_W = 7,
   parameter int TIMEOUT_CYC = 4096,
   parameter int TO_W = 12
) (
   input  logic             glb_clk,
   input  logic             glb_rstn,
   input  logic             Cfg_ctrl_protocal_en,
   input  logic             Cfg_ctrl_Rx_en,
   input  logic [7:0]       Cfg_data_address,
   input  logic [7:0]       Cfg_data_endframe,
   input  logic             UART_core_ctrl_rx_valid,
   input  logic [7:0]       UART_core_data_rxdata,
   input  logic             FIFO_ctrl_full,
   output logic             PROT_STM_ctrl_FIFO_w_en,
   output logic [7:0]       PROT_STM_data_wdata,
   output logic             PROT_STM_ctrl_frame_done,
   output logic             PROT_STM_ctrl_frame_err,
   output logic             PROT_STM_ctrl_overflow,
   output logic [CNT_W-1:0] PROT_STM_data_payload_cnt
);
   prot_state_e state, eff;
   logic [CNT_W-1:0] cnt;
   logic rx_fire, is_end, is_addr, at_max, wr_due, to_expire;

   assign rx_fire = UART_core_ctrl_rx_valid & Cfg_ctrl_Rx_en;
   assign eff = eff_state(state, Cfg_ctrl_protocal_en);
   assign is_end = UART_core_data_rxdata == Cfg_data_endframe;
   assign is_addr = UART_core_data_rxdata == Cfg_data_address;
   assign at_max = cnt == CNT_W'(MAX_LEN);
   assign wr_due = rx_fire & ((eff == NO_PROT) | ((eff == RECV) & !is_end & !at_max));

   recv_frame_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .TO_W(TO_W)
   ) u_timer (
      .clk(glb_clk),
      .rst_n(glb_rstn),
      .clr(rx_fire | (state != RECV)),
      .en(Cfg_ctrl_Rx_en & (state == RECV)),
      .expire(to_expire)
   );

   always_ff @(posedge glb_clk or negedge glb_rstn) begin
      if (!glb_rstn) begin
         state <= NO_PROT;
         cnt <= '0;
         PROT_STM_ctrl_FIFO_w_en <= 1'b0;
         PROT_STM_data_wdata <= '0;
         PROT_STM_ctrl_frame_done <= 1'b0;
         PROT_STM_ctrl_frame_err <= 1'b0;
         PROT_STM_ctrl_overflow <= 1'b0;
         PROT_STM_data_payload_cnt <= '0;
      end else begin
         PROT_STM_ctrl_FIFO_w_en <= wr_due & !FIFO_ctrl_full;
         PROT_STM_ctrl_overflow <= wr_due & FIFO_ctrl_full;
         if (wr_due & !FIFO_ctrl_full) PROT_STM_data_wdata <= UART_core_data_rxdata;
         PROT_STM_ctrl_frame_done <= 1'b0;
         PROT_STM_ctrl_frame_err <= 1'b0;
         if (Cfg_ctrl_Rx_en) begin
            state <= eff;
            if (state == RECV && !Cfg_ctrl_protocal_en) PROT_STM_ctrl_frame_err <= 1'b1;
            if (rx_fire) begin
               case (eff)
                  WAIT_ADDR: if (!is_end) begin
                     state <= is_addr ? RECV : DROP;
                     cnt <= '0;
                  end
                  RECV: if (is_end) begin
                     PROT_STM_ctrl_frame_done <= 1'b1;
                     PROT_STM_data_payload_cnt <= cnt;
                     state <= WAIT_ADDR;
                  end else if (at_max) begin
                     PROT_STM_ctrl_frame_err <= 1'b1;
                     state <= DROP;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
                  DROP: if (is_end) state <= WAIT_ADDR;
                  default: ;
               endcase
            end else if (eff == RECV && to_expire) begin
               PROT_STM_ctrl_frame_err <= 1'b1;
               state <= WAIT_ADDR;
            end
         end
      end
   end
endmodule

// File: tb/tb_recv_protocal_stm.sv
// tb_recv_protocal_stm: directed frames checked every cycle against a frame-level reference model
module tb_recv_protocal_stm;
   import recv_protocal_stm_pkg::*;
   localparam int MAXL = 4;
   localparam int CW = 3;
   localparam int TO = 20;

   logic glb_clk = 1'b0, glb_rstn = 1'b0;
   logic prot = 1'b0, rx_en = 1'b1, rx_valid = 1'b0, full = 1'b0;
   logic [7:0] addr = DEF_ADDRESS, endf = DEF_ENDFRAME, rxd = 8'h00;
   logic w_en, done, err, ovf;
   logic [7:0] wdata;
   logic [CW-1:0] pcnt;

   always #5 glb_clk = ~glb_clk;

   recv_protocal_stm #(.MAX_LEN(MAXL), .CNT_W(CW), .TIMEOUT_CYC(TO), .TO_W(5)) dut (
      .glb_clk(glb_clk),
      .glb_rstn(glb_rstn),
      .Cfg_ctrl_protocal_en(prot),
      .Cfg_ctrl_Rx_en(rx_en),
      .Cfg_data_address(addr),
      .Cfg_data_endframe(endf),
      .UART_core_ctrl_rx_valid(rx_valid),
      .UART_core_data_rxdata(rxd),
      .FIFO_ctrl_full(full),
      .PROT_STM_ctrl_FIFO_w_en(w_en),
      .PROT_STM_data_wdata(wdata),
      .PROT_STM_ctrl_frame_done(done),
      .PROT_STM_ctrl_frame_err(err),
      .PROT_STM_ctrl_overflow(ovf),
      .PROT_STM_data_payload_cnt(pcnt)
   );

   // Reference model: frame-level flags plus an idle-cycle count since the last byte
   bit m_in = 0, m_drop = 0;
   int m_len = 0, m_idle = 0;
   logic e_wen = 0, e_done = 0, e_err = 0, e_ovf = 0;
   logic [7:0] e_wdata = 0;
   logic [CW-1:0] e_pcnt = 0;

   task automatic deliver(logic [7:0] b);
      if (full) e_ovf = 1;
      else begin
         e_wen = 1;
         e_wdata = b;
      end
   endtask

   always @(posedge glb_clk) begin
      e_wen = 0; e_done = 0; e_err = 0; e_ovf = 0;
      if (!glb_rstn) begin
         m_in = 0; m_drop = 0; m_len = 0; m_idle = 0; e_wdata = 0; e_pcnt = 0;
      end else if (rx_en) begin
         if (!prot) begin
            e_err = m_in;
            m_in = 0;
            m_drop = 0;
            if (rx_valid) deliver(rxd);
         end else if (rx_valid) begin
            m_idle = 0;
            if (m_in) begin
               if (rxd == endf) begin
                  e_done = 1; e_pcnt = CW'(m_len); m_in = 0;
               end else if (m_len == MAXL) begin
                  e_err = 1; m_in = 0; m_drop = 1;
               end else begin
                  m_len++;
                  deliver(rxd);
               end
            end else if (m_drop) m_drop = (rxd != endf);
            else if (rxd != endf) begin
               if (rxd == addr) begin m_in = 1; m_len = 0; end
               else m_drop = 1;
            end
         end else if (m_in) begin
            m_idle++;
            if (m_idle == TO) begin e_err = 1; m_in = 0; end
         end
      end
   end

   int checks = 0, errors = 0, cyc = 0;
   int got[$], got_cyc[$];
   int n_done = 0, n_err = 0, n_ovf = 0, err_cyc = -1, s = 0;

   task automatic cmp_cycle();
      checks++;
      if ({w_en, wdata, done, err, ovf, pcnt} !== {e_wen, e_wdata, e_done, e_err, e_ovf, e_pcnt}) begin
         errors++;
         $display("FAIL cycle %0d outputs: got wen=%b wdata=%h done=%b err=%b ovf=%b cnt=%0d, need wen=%b wdata=%h done=%b err=%b ovf=%b cnt=%0d",
                  cyc, w_en, wdata, done, err, ovf, pcnt, e_wen, e_wdata, e_done, e_err, e_ovf, e_pcnt);
      end
      if (w_en === 1'b1) begin got.push_back(int'(wdata)); got_cyc.push_back(cyc); end
      if (done === 1'b1) n_done++;
      if (err === 1'b1) begin n_err++; err_cyc = cyc; end
      if (ovf === 1'b1) n_ovf++;
   endtask

   task automatic tick();
      @(negedge glb_clk);
      cmp_cycle();
      @(posedge glb_clk);
      cyc++;
      #1;
   endtask

   task automatic send(logic [7:0] b);
      rx_valid = 1'b1;
      rxd = b;
      tick();
      rx_valid = 1'b0;
      rxd = 8'h00;
   endtask

   task automatic clear_log();
      got.delete(); got_cyc.delete();
      n_done = 0; n_err = 0; n_ovf = 0; err_cyc = -1;
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, need %0d", name, act, exp);
      end
   endtask

   task automatic chk_w(string name, int cnt, logic [63:0] exp);
      chk({name, " writes"}, got.size(), cnt);
      for (int i = 0; i < cnt && i < got.size(); i++)
         chk($sformatf("%s byte%0d", name, i), got[i], int'((exp >> (8 * (cnt - 1 - i))) & 64'hFF));
   endtask

   initial begin
      tick(); tick();
      chk("reset w_en", int'(w_en), 0);
      chk("reset done", int'(done), 0);
      chk("reset err", int'(err), 0);
      chk("reset payload_cnt", int'(pcnt), 0);
      glb_rstn = 1'b1;
      clear_log();
      // raw pass-through
      send(8'h11); s = cyc; send(8'h22); tick(); tick();
      chk_w("passthru", 2, 64'h1122);
      chk("passthru latency", got_cyc.size() > 0 ? got_cyc[0] - s : -1, 0);
      chk("passthru pulses", n_done + n_err, 0);
      // simple frame
      prot = 1'b1; tick(); clear_log();
      send(8'h5A); send(8'h01); send(8'h02); send(8'h03); send(8'h7E); tick(); tick();
      chk_w("frame3", 3, 64'h010203);
      chk("frame3 done", n_done, 1);
      chk("frame3 payload_cnt", int'(pcnt), 3);
      // foreign frame dropped, then own frame
      clear_log();
      send(8'h33); send(8'h01); send(8'h7E); send(8'h5A); send(8'h09); send(8'h7E); tick(); tick();
      chk_w("drop then frame", 1, 64'h09);
      chk("drop then frame done", n_done, 1);
      chk("drop then frame payload_cnt", int'(pcnt), 1);
      // payload over MAX_LEN
      clear_log();
      send(8'h5A);
      for (int i = 1; i <= 6; i++) send(8'hA0 + 8'(i));
      send(8'h77); send(8'h7E); tick(); tick();
      chk_w("overlong", 4, 64'hA1A2A3A4);
      chk("overlong err", n_err, 1);
      chk("overlong done", n_done, 0);
      chk("overlong payload_cnt held", int'(pcnt), 1);
      // inter-byte timeout
      clear_log();
      send(8'h5A); send(8'h01); s = cyc;
      repeat (TO + 4) tick();
      chk("timeout delay", err_cyc - s, TO);
      chk("timeout err", n_err, 1);
      send(8'h5A); send(8'h05); send(8'h06); send(8'h7E); tick(); tick();
      chk_w("after timeout", 3, 64'h010506);
      chk("after timeout payload_cnt", int'(pcnt), 2);
      // FIFO full on the middle payload byte
      clear_log();
      send(8'h5A); send(8'h01); full = 1'b1; send(8'h02); full = 1'b0; send(8'h03); send(8'h7E); tick(); tick();
      chk_w("fifo full", 2, 64'h0103);
      chk("fifo full overflow", n_ovf, 1);
      chk("fifo full done", n_done, 1);
      chk("fifo full payload_cnt", int'(pcnt), 3);
      // receive disabled
      clear_log();
      rx_en = 1'b0; send(8'h5A); send(8'h01); send(8'h7E); rx_en = 1'b1; tick(); tick();
      chk("rx disabled writes", got.size(), 0);
      chk("rx disabled pulses", n_done + n_err, 0);
      // protocol turned off mid-frame
      clear_log();
      send(8'h5A); send(8'h01); tick(); prot = 1'b0; tick(); send(8'h44); tick(); tick();
      chk_w("mode drop", 2, 64'h0144);
      chk("mode drop err", n_err, 1);
      chk("mode drop done", n_done, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/recv_protocal_stm.md
# recv_protocal_stm

Receive-side framing state machine for the UART controller, sitting between the UART RX core and the RX FIFO. It mirrors the transmit framing of address byte, then payload, then end-frame byte. In protocol mode it accepts a frame only when the first byte matches the configured address, and writes payload bytes to the RX FIFO. It strips the address and end-frame bytes, and reports frame completion, errors, and payload length. With protocol disabled, every received byte passes straight to the FIFO.

## Interface
Parameters:
- MAX_LEN, 64: maximum payload bytes per frame.
- CNT_W, 7: payload counter width; must satisfy 2^CNT_W > MAX_LEN.
- TIMEOUT_CYC, 4096: idle cycles allowed between bytes inside a frame.
- TO_W, 12: timeout counter width; must satisfy 2^TO_W ≥ TIMEOUT_CYC.

Ports (one clock; reset is asynchronous and active-low):
- glb_clk  in  1  system clock; all state changes on the rising edge.
- glb_rstn  in  1  asynchronous active-low reset.
- Cfg_ctrl_protocal_en  in  1  1 = framed mode, 0 = raw pass-through.
- Cfg_ctrl_Rx_en  in  1  receive enable; 0 = received bytes ignored.
- Cfg_data_address  in  8  this node's address.
- Cfg_data_endframe  in  8  end-frame marker value.
- UART_core_ctrl_rx_valid  in  1  one-cycle pulse: a byte is available.
- UART_core_data_rxdata  in  8  received byte; valid only with rx_valid.
- FIFO_ctrl_full  in  1  RX FIFO full.
- PROT_STM_ctrl_FIFO_w_en  out  1  FIFO write strobe.
- PROT_STM_data_wdata  out  8  FIFO write data.
- PROT_STM_ctrl_frame_done  out  1  pulse: a good frame has ended.
- PROT_STM_ctrl_frame_err  out  1  pulse: the frame was aborted.
- PROT_STM_ctrl_overflow  out  1  pulse: a byte was dropped because the FIFO was full.
- PROT_STM_data_payload_cnt  out  CNT_W  payload length of the last completed frame.

## Operation
States:
- NO_PROT: raw pass-through mode.
- WAIT_ADDR: framed mode, waiting for the address byte.
- RECV: receiving payload.
- DROP: discarding bytes until the next end-frame.

NO_PROT:
- On rx_valid & Rx_en, the byte is written to the FIFO.
- If protocal_en=1, go to WAIT_ADDR.

WAIT_ADDR:
- If protocal_en=0, go to NO_PROT.
- On rx_valid & Rx_en with byte == address: clear the running count and the timeout counter, go to RECV.
- On rx_valid & Rx_en with byte == endframe: stay in WAIT_ADDR, no pulse.
- On rx_valid & Rx_en with any other byte: go to DROP.

RECV, on rx_valid:
- byte == endframe: pulse frame_done, load payload_cnt with the running count, go to WAIT_ADDR.
- Otherwise, if running count == MAX_LEN: pulse frame_err, go to DROP; the byte is not written.
- Otherwise: write the byte and increment the running count.

RECV, without rx_valid:
- The timeout counter increments every cycle; rx_valid resets it to 0.
- When it reaches TIMEOUT_CYC-1: pulse frame_err, go to WAIT_ADDR.

RECV, mode change:
- If protocal_en=0: pulse frame_err, go to NO_PROT.
- This check takes priority over byte handling in the same cycle.

DROP:
- Bytes are discarded.
- A byte == endframe returns the machine to WAIT_ADDR with no pulse.
- If protocal_en=0, go to NO_PROT.

Rx_en=0:
- rx_valid is ignored in all states.
- The state and the timeout counter are held.

FIFO full:
- If a write is due while FIFO_ctrl_full=1, the write is suppressed and overflow pulses.
- In RECV, the running count still increments, and frame_done still occurs at end-frame.

Byte comparison order:
- endframe is checked before address, so an address equal to the endframe value never opens a frame.

## Timing
- All outputs are registered. Reset values: all outputs 0, running count 0, state NO_PROT.
- Latency from rx_valid to w_en/wdata is 1 cycle. w_en is high for exactly 1 cycle per accepted byte.
- frame_done and frame_err are 1-cycle pulses, asserted the cycle after the triggering rx_valid or timeout.
- payload_cnt updates in the same cycle as the frame_done pulse and holds until the next frame_done.
- A configuration change is sampled at the clock edge; the byte arriving in that same cycle is processed in the new state, as described under Operation.
- Reset mid-frame: immediate return to NO_PROT, with no pulses.
- Back-to-back rx_valid pulses on consecutive cycles are supported, with no throughput loss.

## Structure
- Shared package (UART protocol layer):
  - State encodings: NO_PROT=0, WAIT_ADDR=1, RECV=2, DROP=3.
  - Default values for the address and endframe bytes, shared with the transmit framing so both ends agree.
- Sub-module recv_frame_timer: the TO_W-bit idle counter, with a clear/enable input and a registered expire output.

## Test plan
- protocal_en=0, bytes 0x11, 0x22 → two writes of 0x11, 0x22, each 1 cycle after rx_valid; no frame pulses.
- address=0x5A, endframe=0x7E, bytes 5A, 01, 02, 03, 7E → writes 01, 02, 03; frame_done pulses; payload_cnt=3.
- Bytes 33, 01, 7E, 5A, 09, 7E → first frame fully dropped; then one write of 09, frame_done, payload_cnt=1.
- MAX_LEN=4, bytes 5A followed by 6 payload bytes → 4 writes, frame_err on the 5th payload byte, remaining bytes dropped until 7E.
- bytes 5A, 01, then silence for TIMEOUT_CYC cycles → frame_err exactly TIMEOUT_CYC cycles after the last rx_valid; state WAIT_ADDR.
- FIFO_ctrl_full=1 during the 2nd of 3 payload bytes → overflow pulse; 2 writes; frame_done with payload_cnt=3. A separate run deasserts protocal_en mid-RECV → frame_err, then pass-through resumes.
